// File: rtl/ora_pkg.sv
// Shared types and default constants for the MISR output response analyser.
// Imported by the top level and available to reference models.
package ora_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [31:0] ORA_TAP_MASK    = 32'h8260_8EDB;
    localparam logic [31:0] ORA_SEED        = 32'h0000_0000;
    localparam int          ORA_NUM_SAMPLES = 62;
    localparam int          ORA_CNT_W       = 16;

endpackage

// File: rtl/misr_fold.sv
// Combinational serial fold of one DATA_W-bit word into a SIG_W-bit MISR state.
// Data bits enter LSB first; each bit shifts the signature right by one.
module misr_fold #(
    parameter int               DATA_W   = 128,
    parameter int               SIG_W    = 32,
    parameter logic [SIG_W-1:0] TAP_MASK = SIG_W'(32'h8260_8EDB)
) (
    input  logic [SIG_W-1:0]  sig_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [SIG_W-1:0]  sig_next
);

    logic [SIG_W-1:0] s;

    always_comb begin
        s = sig_in;
        for (int i = 0; i < DATA_W; i++) begin
            s = {data_in[i] ^ (^(s & TAP_MASK)), s[SIG_W-1:1]};
        end
        sig_next = s;
    end

endmodule

// File: rtl/ora_misr_multi.sv
// MISR output response analyser: folds a windowed response stream into a
// signature, compares it against a golden value, reports via done/pass.
module ora_misr_multi
    import ora_pkg::*;
#(
    parameter int               DATA_W      = 128,
    parameter int               SIG_W       = 32,
    parameter logic [SIG_W-1:0] TAP_MASK    = SIG_W'(ORA_TAP_MASK),
    parameter logic [SIG_W-1:0] SEED        = SIG_W'(ORA_SEED),
    parameter int               NUM_SAMPLES = ORA_NUM_SAMPLES,
    parameter bit               SKIP_REPEAT = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SIG_W-1:0]  golden,
    output logic [SIG_W-1:0]  sig_out,
    output logic              done,
    output logic              pass
);

    localparam int             CNT_W    = ORA_CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES - 1);

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] last_word;
    logic              hist_vld;
    logic [SIG_W-1:0]  sig_fold;
    logic [SIG_W-1:0]  sig_acc;
    logic              accept;
    logic              is_repeat;
    logic              last_accept;

    misr_fold #(
        .DATA_W  (DATA_W),
        .SIG_W   (SIG_W),
        .TAP_MASK(TAP_MASK)
    ) u_fold (
        .sig_in  (sig_out),
        .data_in (in_data),
        .sig_next(sig_fold)
    );

    assign in_ready    = (state == RUN);
    assign done        = (state == DONE);
    // start takes priority: a word presented alongside it is dropped
    assign accept      = in_ready && in_valid && !start;
    assign is_repeat   = SKIP_REPEAT && hist_vld && (in_data == last_word);
    assign sig_acc     = is_repeat ? sig_out : sig_fold;
    assign last_accept = accept && (count == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN: begin
                if (start)            state_next = RUN;
                else if (last_accept) state_next = DONE;
            end
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_out  <= SEED;
            count    <= '0;
            hist_vld <= 1'b0;
            pass     <= 1'b0;
        end else if (start) begin
            sig_out  <= SEED;
            count    <= '0;
            hist_vld <= 1'b0;
            pass     <= 1'b0;
        end else if (accept) begin
            sig_out  <= sig_acc;
            count    <= count + 1'b1;
            hist_vld <= 1'b1;
            if (last_accept) begin
                pass <= (sig_acc == golden);
            end
        end
    end

    // History word only matters when hist_vld is set, so it needs no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            last_word <= in_data;
        end
    end

endmodule

// File: tb/tb_ora_misr_multi.sv
// Directed self-checking bench for ora_misr_multi: one default 128/32 instance
// and three 4/4 instances that differ in window length and repeat mode.
module tb_ora_misr_multi;

    localparam logic [31:0] BIG_TAP = 32'h8260_8EDB;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         b_start = 1'b0, b_valid = 1'b0, b_ready, b_done, b_pass;
    logic [127:0] b_data  = '0;
    logic [31:0]  b_golden = '0, b_sig;

    logic         s_start = 1'b0, s_valid = 1'b0;
    logic [3:0]   s_data = '0, s_golden = '0;
    logic         r1_ready, r1_done, r1_pass;
    logic         r2_ready, r2_done, r2_pass;
    logic         r3_ready, r3_done, r3_pass;
    logic [3:0]   r1_sig, r2_sig, r3_sig;

    int checks   = 0;
    int failures = 0;

    ora_misr_multi u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .golden(b_golden), .sig_out(b_sig), .done(b_done), .pass(b_pass)
    );

    ora_misr_multi #(.DATA_W(4), .SIG_W(4), .TAP_MASK(4'b0011), .SEED(4'h0),
                     .NUM_SAMPLES(1), .SKIP_REPEAT(1'b1)) u_s1 (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(r1_ready),
        .in_data(s_data), .golden(s_golden), .sig_out(r1_sig), .done(r1_done), .pass(r1_pass)
    );

    ora_misr_multi #(.DATA_W(4), .SIG_W(4), .TAP_MASK(4'b0011), .SEED(4'h0),
                     .NUM_SAMPLES(2), .SKIP_REPEAT(1'b1)) u_s2 (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(r2_ready),
        .in_data(s_data), .golden(s_golden), .sig_out(r2_sig), .done(r2_done), .pass(r2_pass)
    );

    ora_misr_multi #(.DATA_W(4), .SIG_W(4), .TAP_MASK(4'b0011), .SEED(4'h0),
                     .NUM_SAMPLES(2), .SKIP_REPEAT(1'b0)) u_s3 (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .in_ready(r3_ready),
        .in_data(s_data), .golden(s_golden), .sig_out(r3_sig), .done(r3_done), .pass(r3_pass)
    );

    // Reference fold for the default instance, bit-serial LSB first
    function automatic logic [31:0] ref_fold(input logic [31:0] s, input logic [127:0] d);
        logic [31:0] st;
        logic        par;
        st = s;
        for (int i = 0; i < 128; i++) begin
            par = 1'b0;
            for (int k = 0; k < 32; k++) if (BIG_TAP[k]) par = par ^ st[k];
            st = {d[i] ^ par, st[31:1]};
        end
        return st;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++; if (b_sig !== 32'h0) begin failures++; $display("FAIL reset_sig got=%h exp=%h", b_sig, 32'h0); end
        checks++; if ({b_ready, b_done, b_pass} !== 3'b000) begin failures++; $display("FAIL reset_ctrl got=%b exp=000", {b_ready, b_done, b_pass}); end
        checks++; if ({r1_ready, r1_done, r1_pass, r1_sig} !== 7'b0) begin failures++; $display("FAIL reset_small got=%b exp=0", {r1_ready, r1_done, r1_pass, r1_sig}); end
        tick();
        rst = 1'b0;
        tick();
        checks++; if (b_ready !== 1'b0) begin failures++; $display("FAIL idle_ready got=%b exp=0", b_ready); end
    endtask

    task automatic test_zero_run();
        b_golden = 32'h0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        checks++; if (b_ready !== 1'b1) begin failures++; $display("FAIL zero_ready_run got=%b exp=1", b_ready); end
        b_valid = 1'b1;
        b_data  = '0;
        for (int k = 0; k < 62; k++) begin
            tick();
            if (k == 30) begin
                checks++; if (b_sig !== 32'h0) begin failures++; $display("FAIL zero_mid_sig got=%h exp=0", b_sig); end
            end
            if (k == 60) begin
                checks++; if ({b_done, b_ready} !== 2'b01) begin failures++; $display("FAIL zero_early_done got=%b exp=01", {b_done, b_ready}); end
            end
        end
        b_valid = 1'b0;
        checks++; if ({b_done, b_pass, b_ready} !== 3'b110) begin failures++; $display("FAIL zero_done got=%b exp=110", {b_done, b_pass, b_ready}); end
        checks++; if (b_sig !== 32'h0) begin failures++; $display("FAIL zero_final_sig got=%h exp=0", b_sig); end
    endtask

    task automatic test_small_fold();
        s_golden = 4'h9;
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_valid = 1'b1; s_data = 4'b0001; tick(); s_valid = 1'b0;
        checks++; if (r1_sig !== 4'h9) begin failures++; $display("FAIL small_sig got=%h exp=9", r1_sig); end
        checks++; if ({r1_done, r1_pass} !== 2'b11) begin failures++; $display("FAIL small_pass got=%b exp=11", {r1_done, r1_pass}); end
        checks++; if ({r2_done, r2_sig} !== 5'h09) begin failures++; $display("FAIL s2_first got=%h exp=09", {r2_done, r2_sig}); end
    endtask

    task automatic test_repeat();
        s_valid = 1'b1; s_data = 4'b0001; tick(); s_valid = 1'b0;
        checks++; if ({r2_done, r2_pass, r2_sig} !== 6'b11_1001) begin failures++; $display("FAIL skip_on got=%b exp=111001", {r2_done, r2_pass, r2_sig}); end
        checks++; if ({r3_done, r3_pass, r3_sig} !== 6'b10_1100) begin failures++; $display("FAIL skip_off got=%b exp=101100", {r3_done, r3_pass, r3_sig}); end
        checks++; if ({r1_done, r1_sig} !== 5'h19) begin failures++; $display("FAIL done_hold got=%h exp=19", {r1_done, r1_sig}); end
        s_golden = 4'h8;
        s_start = 1'b1; tick(); s_start = 1'b0;
        s_valid = 1'b1; s_data = 4'b0001; tick(); s_valid = 1'b0;
        checks++; if ({r1_done, r1_pass, r1_sig} !== 6'b10_1001) begin failures++; $display("FAIL small_fail got=%b exp=101001", {r1_done, r1_pass, r1_sig}); end
    endtask

    task automatic test_gaps();
        logic [127:0] words [62];
        logic [31:0]  exp_sig;
        logic [127:0] prev;
        logic         hv;
        int           acc;
        int           cyc;
        logic         v;
        for (int k = 0; k < 62; k++) begin
            if (k > 0 && $urandom_range(0, 3) == 0) words[k] = words[k-1];
            else words[k] = {$urandom, $urandom, $urandom, $urandom};
        end
        exp_sig = 32'h0; hv = 1'b0; prev = '0;
        for (int k = 0; k < 62; k++) begin
            if (!(hv && words[k] == prev)) exp_sig = ref_fold(exp_sig, words[k]);
            prev = words[k]; hv = 1'b1;
        end
        // Words in DONE must be ignored
        b_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            b_data = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        b_valid = 1'b0;
        checks++; if ({b_done, b_pass, b_sig} !== {2'b11, 32'h0}) begin failures++; $display("FAIL done_ignore got=%h exp=%h", {b_done, b_pass, b_sig}, {2'b11, 32'h0}); end
        b_golden = exp_sig;
        b_start = 1'b1; tick(); b_start = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 62 && cyc < 2000) begin
            v = 1'($urandom_range(0, 1));
            b_valid = v;
            b_data  = v ? words[acc] : {$urandom, $urandom, $urandom, $urandom};
            tick();
            cyc++;
            if (v) acc++;
        end
        b_valid = 1'b0;
        checks++; if (acc !== 62) begin failures++; $display("FAIL gaps_budget got=%0d exp=62", acc); end
        checks++; if (b_sig !== exp_sig) begin failures++; $display("FAIL gaps_sig got=%h exp=%h", b_sig, exp_sig); end
        checks++; if ({b_done, b_pass} !== 2'b11) begin failures++; $display("FAIL gaps_pass got=%b exp=11", {b_done, b_pass}); end
    endtask

    task automatic test_restart();
        logic [31:0] exp_sig;
        exp_sig = 32'h0;
        for (int k = 0; k < 62; k++) exp_sig = ref_fold(exp_sig, {4{32'(k * 7 + 3)}});
        b_golden = exp_sig;
        b_start = 1'b1; tick(); b_start = 1'b0;
        b_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            b_data = 128'(k + 1);
            tick();
        end
        checks++; if (b_sig === 32'h0) begin failures++; $display("FAIL restart_pre got=%h exp=nonzero", b_sig); end
        b_start = 1'b1; b_data = 128'hDEAD; tick(); b_start = 1'b0;
        checks++; if ({b_ready, b_sig} !== {1'b1, 32'h0}) begin failures++; $display("FAIL restart_seed got=%h exp=%h", {b_ready, b_sig}, {1'b1, 32'h0}); end
        for (int k = 0; k < 62; k++) begin
            b_data = {4{32'(k * 7 + 3)}};
            tick();
            if (k == 60) begin
                checks++; if (b_done !== 1'b0) begin failures++; $display("FAIL restart_early got=%b exp=0", b_done); end
            end
        end
        b_valid = 1'b0;
        checks++; if (b_sig !== exp_sig) begin failures++; $display("FAIL restart_sig got=%h exp=%h", b_sig, exp_sig); end
        checks++; if ({b_done, b_pass} !== 2'b11) begin failures++; $display("FAIL restart_pass got=%b exp=11", {b_done, b_pass}); end
    endtask

    task automatic test_async_reset();
        s_golden = 4'h9;
        s_start = 1'b1; b_start = 1'b1; tick(); s_start = 1'b0; b_start = 1'b0;
        s_valid = 1'b1; s_data = 4'b0001; b_valid = 1'b1; b_data = 128'h1; tick(); s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b_data = 128'(k + 2);
            tick();
        end
        checks++; if ({r1_done, r1_pass, r3_sig} !== 6'b11_1001) begin failures++; $display("FAIL pre_reset got=%b exp=111001", {r1_done, r1_pass, r3_sig}); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if ({r1_done, r1_pass, r3_ready, r3_sig} !== 7'b0) begin failures++; $display("FAIL async_small got=%b exp=0", {r1_done, r1_pass, r3_ready, r3_sig}); end
        checks++; if ({b_ready, b_done, b_pass, b_sig} !== 35'b0) begin failures++; $display("FAIL async_big got=%h exp=0", {b_ready, b_done, b_pass, b_sig}); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        b_valid = 1'b0;
        checks++; if ({b_ready, b_done, b_pass, b_sig} !== 35'b0) begin failures++; $display("FAIL post_reset got=%h exp=0", {b_ready, b_done, b_pass, b_sig}); end
    endtask

    initial begin
        test_reset();
        test_zero_run();
        test_small_fold();
        test_repeat();
        test_gaps();
        test_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
